// File: rtl/stack_pkg.sv
// rtl/stack_pkg.sv - opcode encoding shared by the stack and its ALU
// Purpose: defines the opcode enum used by stack and stack_alu.
// Ports: none (package).
package stack_pkg;

    // Opcodes 001..011 are not listed and also decode as NOP.
    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_ADD  = 3'b100,
        OP_MUL  = 3'b101,
        OP_PUSH = 3'b110,
        OP_POP  = 3'b111
    } stack_op_e;

endpackage

// File: rtl/stack_alu.sv
// rtl/stack_alu.sv - combinational signed add/multiply unit for the stack
// Purpose: computes NOS op TOS, truncated to WIDTH, with a signed overflow flag.
// Ports:
//   a_i      : first operand (NOS), two's complement
//   b_i      : second operand (TOS), two's complement
//   op_i     : opcode; OP_MUL selects multiply, anything else selects add
//   result_o : truncated WIDTH-bit result
//   ovf_o    : signed overflow of the selected operation
module stack_alu
    import stack_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [2:0]       op_i,
    output logic [WIDTH-1:0] result_o,
    output logic             ovf_o
);

    logic [WIDTH-1:0]          sum;
    logic                      sum_ovf;
    logic signed [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]          prod_lo;
    logic                      prod_ovf;

    assign sum     = a_i + b_i;
    // Same-sign operands whose sum flips sign have left the representable range.
    assign sum_ovf = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);

    // Operands are sign-extended to 2*WIDTH so the product is exact.
    assign prod     = $signed({{WIDTH{a_i[WIDTH-1]}}, a_i}) * $signed({{WIDTH{b_i[WIDTH-1]}}, b_i});
    assign prod_lo  = prod[WIDTH-1:0];
    assign prod_ovf = (prod != $signed({{WIDTH{prod_lo[WIDTH-1]}}, prod_lo}));

    assign result_o = (op_i == OP_MUL) ? prod_lo  : sum;
    assign ovf_o    = (op_i == OP_MUL) ? prod_ovf : sum_ovf;

endmodule

// File: rtl/stack.sv
// rtl/stack.sv - synchronous LIFO operand stack with signed add/multiply
// Purpose: one opcode per clock (push, pop, add, mul); arithmetic consumes
//          TOS and NOS and writes the result back as the new TOS.
// Ports:
//   clk         : clock, all state changes on rising edge
//   rst_n       : synchronous active-low reset
//   opcode      : operation code (see stack_pkg)
//   input_data  : operand for PUSH
//   output_data : registered result of last POP/ADD/MUL
//   empty       : stack holds no entries
//   full        : stack holds DEPTH entries
//   overflow    : registered signed overflow of last executed ADD/MUL
module stack
    import stack_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       opcode,
    input  logic [WIDTH-1:0] input_data,
    output logic [WIDTH-1:0] output_data,
    output logic             empty,
    output logic             full,
    output logic             overflow
);

    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SPW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [SPW-1:0]   sp_q, sp_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             ovf_q, ovf_d;

    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [WIDTH-1:0] mem_wdata;

    logic [AW-1:0]    sp_lo, tos_idx, nos_idx;
    logic [WIDTH-1:0] tos, nos;
    logic             has_two;
    logic [WIDTH-1:0] alu_result;
    logic             alu_ovf;

    // Low bits of sp address the memory; modular subtraction gives the
    // correct TOS/NOS slots even when sp == DEPTH.
    assign sp_lo   = sp_q[AW-1:0];
    assign tos_idx = sp_lo - AW'(1);
    assign nos_idx = sp_lo - AW'(2);
    assign tos     = mem_q[tos_idx];
    assign nos     = mem_q[nos_idx];

    assign empty   = (sp_q == '0);
    assign full    = (sp_q == SPW'(DEPTH));
    assign has_two = (sp_q >= SPW'(2));

    stack_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .a_i      (nos),
        .b_i      (tos),
        .op_i     (opcode),
        .result_o (alu_result),
        .ovf_o    (alu_ovf)
    );

    always_comb begin
        sp_d      = sp_q;
        out_d     = out_q;
        ovf_d     = ovf_q;
        mem_we    = 1'b0;
        mem_waddr = sp_lo;
        mem_wdata = input_data;
        case (opcode)
            OP_PUSH: begin
                if (!full) begin
                    mem_we = 1'b1;
                    sp_d   = sp_q + SPW'(1);
                end
            end
            OP_POP: begin
                if (!empty) begin
                    out_d = tos;
                    sp_d  = sp_q - SPW'(1);
                end
            end
            OP_ADD, OP_MUL: begin
                // Fewer than two operands: treated as NOP, flags hold.
                if (has_two) begin
                    mem_we    = 1'b1;
                    mem_waddr = nos_idx;
                    mem_wdata = alu_result;
                    sp_d      = sp_q - SPW'(1);
                    out_d     = alu_result;
                    ovf_d     = alu_ovf;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sp_q  <= '0;
            out_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            sp_q  <= sp_d;
            out_q <= out_d;
            ovf_q <= ovf_d;
        end
    end

    // Memory contents are don't-care after reset, so no reset branch here.
    always_ff @(posedge clk) begin
        if (rst_n && mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign output_data = out_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_stack.sv
// tb/tb_stack.sv - self-checking testbench for stack
module tb_stack;

    localparam int DEPTH = 256;
    localparam int WIDTH = 16;

    localparam logic [2:0] NOP  = 3'b000;
    localparam logic [2:0] ADD  = 3'b100;
    localparam logic [2:0] MUL  = 3'b101;
    localparam logic [2:0] PUSH = 3'b110;
    localparam logic [2:0] POP  = 3'b111;

    logic             clk;
    logic             rst_n;
    logic [2:0]       opcode;
    logic [WIDTH-1:0] input_data;
    logic [WIDTH-1:0] output_data;
    logic             empty;
    logic             full;
    logic             overflow;

    int n_tests;
    int n_fail;

    // Reference model: a queue used as a LIFO, plus the two registered outputs.
    logic signed [WIDTH-1:0] mq[$];
    logic [WIDTH-1:0]        m_out;
    logic                    m_ovf;

    stack #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .opcode      (opcode),
        .input_data  (input_data),
        .output_data (output_data),
        .empty       (empty),
        .full        (full),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_apply(input logic [2:0] op, input logic [WIDTH-1:0] d);
        logic signed [WIDTH-1:0] a, b;
        int     s;
        longint p;
        case (op)
            PUSH: if (mq.size() < DEPTH) mq.push_back(d);
            POP:  if (mq.size() > 0) m_out = mq.pop_back();
            ADD, MUL: begin
                if (mq.size() >= 2) begin
                    b = mq.pop_back();
                    a = mq.pop_back();
                    if (op == ADD) begin
                        s     = int'(a) + int'(b);
                        m_ovf = (s > 32767) || (s < -32768);
                        m_out = s[WIDTH-1:0];
                    end else begin
                        p     = longint'(a) * longint'(b);
                        m_ovf = (p > 32767) || (p < -32768);
                        m_out = p[WIDTH-1:0];
                    end
                    mq.push_back(m_out);
                end
            end
            default: ;
        endcase
    endtask

    task automatic step(input logic [2:0] op, input logic [WIDTH-1:0] d);
        rst_n      = 1'b1;
        opcode     = op;
        input_data = d;
        @(posedge clk);
        #1;
        model_apply(op, d);
        opcode = NOP;
    endtask

    task automatic apply_reset(input logic [2:0] op);
        rst_n      = 1'b0;
        opcode     = op;
        input_data = WIDTH'($urandom);
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        opcode = NOP;
        mq.delete();
        m_out = '0;
        m_ovf = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset(PUSH);
        n_tests++;
        if (empty !== 1'b1 || full !== 1'b0 || output_data !== 16'h0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: empty=%b full=%b out=%h ovf=%b, want 1 0 0000 0",
                     empty, full, output_data, overflow);
        end
    endtask

    task automatic test_fill_drain();
        apply_reset(NOP);
        for (int i = 1; i <= DEPTH; i++) begin
            step(PUSH, WIDTH'(i));
            n_tests++;
            if (full !== (i == DEPTH)) begin
                n_fail++;
                $display("FAIL fill_full_flag i=%0d: full=%b want %b", i, full, (i == DEPTH));
            end
        end
        step(PUSH, 16'd257);
        n_tests++;
        if (full !== 1'b1 || empty !== 1'b0) begin
            n_fail++;
            $display("FAIL push_when_full: full=%b empty=%b want 1 0", full, empty);
        end
        for (int i = DEPTH; i >= 1; i--) begin
            step(POP, '0);
            n_tests++;
            if (output_data !== WIDTH'(i) || empty !== (i == 1) || full !== 1'b0) begin
                n_fail++;
                $display("FAIL drain i=%0d: out=%0d empty=%b full=%b want %0d %b 0",
                         i, output_data, empty, full, i, (i == 1));
            end
        end
        step(POP, '0);
        n_tests++;
        if (output_data !== 16'd1 || empty !== 1'b1) begin
            n_fail++;
            $display("FAIL pop_when_empty: out=%0d empty=%b want 1 1", output_data, empty);
        end
    endtask

    task automatic test_add();
        apply_reset(NOP);
        step(PUSH, 16'd1);
        step(PUSH, 16'hFFFE);
        step(ADD, '0);
        n_tests++;
        if (output_data !== 16'hFFFF || overflow !== 1'b0 || empty !== 1'b0) begin
            n_fail++;
            $display("FAIL add_basic: out=%h ovf=%b empty=%b want ffff 0 0", output_data, overflow, empty);
        end
        step(POP, '0);
        n_tests++;
        if (output_data !== 16'hFFFF || empty !== 1'b1) begin
            n_fail++;
            $display("FAIL add_one_left: out=%h empty=%b want ffff 1", output_data, empty);
        end
    endtask

    task automatic test_mul();
        apply_reset(NOP);
        step(PUSH, 16'hFFFD);
        step(PUSH, 16'd4);
        step(MUL, '0);
        n_tests++;
        if (output_data !== 16'hFFF4 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL mul_basic: out=%h ovf=%b want fff4 0", output_data, overflow);
        end
    endtask

    task automatic test_overflow();
        apply_reset(NOP);
        step(PUSH, 16'h7FFF);
        step(PUSH, 16'h0001);
        step(ADD, '0);
        n_tests++;
        if (output_data !== 16'h8000 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL add_ovf: out=%h ovf=%b want 8000 1", output_data, overflow);
        end
        apply_reset(NOP);
        step(PUSH, 16'h8001);
        step(PUSH, 16'hFFFE);
        step(MUL, '0);
        n_tests++;
        if (output_data !== 16'hFFFE || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL mul_ovf: out=%h ovf=%b want fffe 1", output_data, overflow);
        end
        step(PUSH, 16'd9);
        n_tests++;
        if (overflow !== 1'b1 || output_data !== 16'hFFFE) begin
            n_fail++;
            $display("FAIL ovf_hold_push: ovf=%b out=%h want 1 fffe", overflow, output_data);
        end
        step(POP, '0);
        step(POP, '0);
        n_tests++;
        if (output_data !== 16'hFFFE || empty !== 1'b1 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_hold_pop: out=%h empty=%b ovf=%b want fffe 1 1", output_data, empty, overflow);
        end
    endtask

    task automatic test_short_arith();
        // Continues from test_overflow: empty stack, output_data=fffe, overflow=1.
        step(ADD, '0);
        step(MUL, '0);
        n_tests++;
        if (empty !== 1'b1 || output_data !== 16'hFFFE || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL arith_on_empty: empty=%b out=%h ovf=%b want 1 fffe 1", empty, output_data, overflow);
        end
        step(PUSH, 16'd5);
        step(ADD, '0);
        step(MUL, '0);
        n_tests++;
        if (empty !== 1'b0 || output_data !== 16'hFFFE || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL arith_one_entry: empty=%b out=%h ovf=%b want 0 fffe 1", empty, output_data, overflow);
        end
        step(POP, '0);
        n_tests++;
        if (output_data !== 16'd5 || empty !== 1'b1) begin
            n_fail++;
            $display("FAIL arith_one_entry_pop: out=%h empty=%b want 0005 1", output_data, empty);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset(NOP);
        step(PUSH, 16'd3);
        step(PUSH, 16'd7);
        step(MUL, '0);
        apply_reset(POP);
        n_tests++;
        if (empty !== 1'b1 || output_data !== 16'h0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: empty=%b out=%h ovf=%b want 1 0000 0", empty, output_data, overflow);
        end
    endtask

    task automatic test_random();
        logic [2:0]       op;
        logic [WIDTH-1:0] d;
        int               r;
        apply_reset(NOP);
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 19);
            if (r < 8)       op = PUSH;
            else if (r < 12) op = POP;
            else if (r < 15) op = ADD;
            else if (r < 18) op = MUL;
            else             op = 3'($urandom_range(0, 3));
            // Mix small values (mostly in-range products) with full-range ones.
            d = ($urandom_range(0, 1) == 0) ? WIDTH'($urandom_range(0, 15) - 8) : WIDTH'($urandom);
            if ($urandom_range(0, 499) == 0) apply_reset(op);
            else step(op, d);
            n_tests++;
            if (output_data !== m_out || overflow !== m_ovf ||
                empty !== (mq.size() == 0) || full !== (mq.size() == DEPTH)) begin
                n_fail++;
                $display("FAIL random cycle %0d op=%b: out=%h ovf=%b empty=%b full=%b want %h %b %b %b",
                         i, op, output_data, overflow, empty, full,
                         m_out, m_ovf, (mq.size() == 0), (mq.size() == DEPTH));
            end
        end
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        opcode     = NOP;
        input_data = '0;
        m_out      = '0;
        m_ovf      = 1'b0;
        test_reset();
        test_fill_drain();
        test_add();
        test_mul();
        test_overflow();
        test_short_arith();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
